fighter_motion_ctrl: RTL and testbench
======================================

Name: fighter_motion_ctrl

Overview:
- Per-player game-logic block that produces the pose and position bus consumed by the sprite renderer: x, y, in_air, move_state, character_state and mirror.
- Converts debounced buttons, a hit pulse and the opponent position into movement, jump arc, punch, special-combo and injured sequences.
- Runs at game-tick rate, derived internally from clk.
- One instance per fighter; outputs go straight to the renderer.

Parameters:
- TICK_DIV, 2_500_000: clk cycles per game tick (40 Hz at 100 MHz).
- X_START, 24: x position after reset.
- MIRROR_INIT, 0: mirror value after reset.
- X_MIN, 8 / X_MAX, 88: inclusive horizontal clamp.
- Y_GROUND, 32: standing y value.
- JUMP_HEIGHT, 16: apex offset above ground, in pixels.
- PUNCH_TICKS, 4: punch duration.
- SPECIAL_TICKS, 8: special-attack duration.
- INJ_TICKS, 6: injured duration.
- COMBO_WINDOW, 8: maximum ticks allowed between consecutive combo inputs.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- btn_left, btn_right, btn_up, btn_down, btn_attack  in  1 each  debounced level inputs
- hit_in  in  1  one-cycle pulse: this fighter was struck
- opponent_x  in  7  opponent x position
- x  out  7  sprite centre x
- y  out  7  sprite centre y
- in_air  out  1  1 while jumping
- move_state  out  2  00 idle, 01 forward, 10 backward
- character_state  out  3  000 normal, 001 punch, 010 special, 100 injured
- mirror  out  1  1 = facing left

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: x=X_START, y=Y_GROUND, in_air=0, move_state=00, character_state=000, mirror=MIRROR_INIT. Reset also clears the tick counter, edge latches, combo history and all duration counters.
- Reset wins over every other event in the same cycle, including mid-jump or mid-attack.
- Tick generation: a counter runs 0..TICK_DIV-1. A one-cycle tick strobe fires on wrap.
- Register update timing: all output registers update only on a cycle where the tick strobe is high.
- Button edges: rising edges are detected every clk and latched. Latches are consumed and cleared on the next tick.
- Hit latching: hit_in is latched the same way and consumed on the next tick.
- Facing: mirror <= (opponent_x < x). It is updated only on ticks where character_state=000 and in_air=0.
- Action FSM states: NORMAL, PUNCH, SPECIAL, INJURED.
- Action FSM priority at each tick: hit > special combo complete > attack edge > countdown expiry.
  - Any state + hit -> INJURED, counter=INJ_TICKS. A hit while already INJURED restarts the counter.
  - NORMAL + combo complete -> SPECIAL, counter=SPECIAL_TICKS.
  - NORMAL + attack edge (no combo) -> PUNCH, counter=PUNCH_TICKS.
  - PUNCH/SPECIAL/INJURED: counter decrements each tick; at 0 -> NORMAL.
  - Attack edges during PUNCH or SPECIAL are ignored.
- Combo detection: left edge, down edge, right edge, attack edge, in that order (absolute directions).
  - Each step must arrive within COMBO_WINDOW ticks of the previous step.
  - Any other direction edge resets progress to step 0, except left, which restarts at step 1.
  - Timeout resets progress to 0.
- Horizontal motion (NORMAL only): exactly one of left/right held -> x moves ±1 per tick.
  - x saturates at X_MIN/X_MAX and never wraps.
  - Moving toward facing gives move_state=01; away gives 10.
  - No movement, both buttons held, or clamped at the limit gives 00.
  - move_state is 00 whenever character_state != 000.
- Jump sub-FSM: GROUND -> RISE on an up edge when GROUND and the action state is NORMAL or PUNCH.
  - RISE: y -= 1 per tick; at Y_GROUND-JUMP_HEIGHT -> FALL.
  - FALL: y += 1 per tick; at Y_GROUND -> GROUND.
  - in_air = (state != GROUND). Horizontal motion continues while airborne.
  - An injury while airborne does not cancel the arc.
- Knockback: in INJURED, x moves 1 per tick away from the facing direction, clamped.

Optional Feature:
- Macro: SUPER_COMBO_EN.
- When defined, a second detector is added. Its sequence is up, down, up, down, left, right, left, right, attack, with the same COMBO_WINDOW rule.
- On completion it enters state SUPER (character_state=011) for 2*SPECIAL_TICKS ticks.
- SUPER has priority above the special combo and below hit.
- When not defined, code 011 is never produced and that logic is absent.

Decomposition:
- Package fighter_pkg holds:
  - character_state codes (NORMAL, PUNCH, SPECIAL, SUPER, INJURED);
  - move_state codes;
  - jump state codes;
  - the combo step encoding.
- Sub-module combo_detector:
  - inputs: tick, edge strobes, reset;
  - output: a one-tick done pulse;
  - parameterised by window length;
  - instantiated once, or twice under SUPER_COMBO_EN.

Test Plan:
- Bench setup: TICK_DIV=4. Assert reset for 2 cycles -> x=24, y=32, in_air=0, move_state=00, character_state=000, mirror=0.
- Hold btn_right 10 ticks with opponent_x=80 -> x=34, move_state=01. Hold btn_left with x=8 -> x stays 8, move_state=00.
- Up edge -> y steps 31..16 over 16 ticks, then back to 32 at tick 32; in_air=1 throughout, 0 after.
- Attack edge -> character_state=001 for 4 ticks, then 000. A hit_in pulse on tick 2 -> 100 for 6 ticks, x knocked back 6 px.
- Left, down, right, attack with 3-tick gaps -> 010 for 8 ticks. Same sequence with a 9-tick gap before attack -> punch only (001).
- Assert reset mid-jump at y=20 during PUNCH -> all outputs return to reset values on the next edge; no residual punch after release.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared encodings for the fighter game-logic block: action, movement and jump
// state codes plus the combo step alphabet and the two combo sequences.
package fighter_pkg;

  typedef enum logic [2:0] {
    CS_NORMAL  = 3'b000,
    CS_PUNCH   = 3'b001,
    CS_SPECIAL = 3'b010,
    CS_SUPER   = 3'b011,
    CS_INJURED = 3'b100
  } char_state_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_FWD  = 2'b01,
    MS_BACK = 2'b10
  } move_state_e;

  typedef enum logic [1:0] {
    JS_GROUND = 2'b00,
    JS_RISE   = 2'b01,
    JS_FALL   = 2'b10
  } jump_state_e;

  // Step codes double as bit positions in the edge-strobe vector.
  localparam int NUM_STEPS = 5;
  localparam logic [2:0] STEP_LEFT   = 3'd0;
  localparam logic [2:0] STEP_RIGHT  = 3'd1;
  localparam logic [2:0] STEP_UP     = 3'd2;
  localparam logic [2:0] STEP_DOWN   = 3'd3;
  localparam logic [2:0] STEP_ATTACK = 3'd4;

  // Element [0] is the first step of each sequence.
  localparam int SPECIAL_LEN = 4;
  localparam logic [SPECIAL_LEN-1:0][2:0] SPECIAL_SEQ =
    {STEP_ATTACK, STEP_RIGHT, STEP_DOWN, STEP_LEFT};

  localparam int SUPER_LEN = 9;
  localparam logic [SUPER_LEN-1:0][2:0] SUPER_SEQ =
    {STEP_ATTACK, STEP_RIGHT, STEP_LEFT, STEP_RIGHT, STEP_LEFT,
     STEP_DOWN, STEP_UP, STEP_DOWN, STEP_UP};

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/combo_detector.sv
// Tracks progress through one button sequence at game-tick rate and pulses
// done (combinationally, on the completing tick) when the last step lands.
module combo_detector
  import fighter_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int LEN = SPECIAL_LEN,
  parameter logic [LEN-1:0][2:0] SEQ = SPECIAL_SEQ
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_STEPS-1:0] edges,
  output logic                 done
);

  localparam int SW = $clog2(LEN);
  localparam int GW = $clog2(WINDOW + 1);

  logic [SW-1:0] step;
  logic [GW-1:0] gap;
  logic          want;
  logic          wrong_dir;

  assign want      = edges[SEQ[step]];
  assign wrong_dir = |edges[STEP_DOWN:STEP_LEFT];
  assign done      = tick && want && (step == SW'(LEN - 1));

  // gap counts idle ticks since the last accepted step; an idle tick that
  // would push the spacing past WINDOW drops the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      step <= '0;
      gap  <= '0;
    end else if (tick) begin
      if (want) begin
        gap  <= '0;
        step <= (step == SW'(LEN - 1)) ? '0 : step + SW'(1);
      end else if (wrong_dir) begin
        gap  <= '0;
        step <= edges[SEQ[0]] ? SW'(1) : '0;
      end else if (step != '0) begin
        if (gap == GW'(WINDOW - 1)) begin
          step <= '0;
          gap  <= '0;
        end else begin
          gap <= gap + GW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fighter_motion_ctrl.sv
// Per-fighter pose/position generator for the sprite renderer, stepped at
// game-tick rate. Define SUPER_COMBO_EN to add the 9-step SUPER attack.
module fighter_motion_ctrl
  import fighter_pkg::*;
#(
  parameter int   TICK_DIV      = 2_500_000,
  parameter int   X_START       = 24,
  parameter logic MIRROR_INIT   = 1'b0,
  parameter int   X_MIN         = 8,
  parameter int   X_MAX         = 88,
  parameter int   Y_GROUND      = 32,
  parameter int   JUMP_HEIGHT   = 16,
  parameter int   PUNCH_TICKS   = 4,
  parameter int   SPECIAL_TICKS = 8,
  parameter int   INJ_TICKS     = 6,
  parameter int   COMBO_WINDOW  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic       hit_in,
  input  logic [6:0] opponent_x,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic [1:0] move_state,
  output logic [2:0] character_state,
  output logic       mirror
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(imax(imax(PUNCH_TICKS, 2 * SPECIAL_TICKS), INJ_TICKS) + 1);
  localparam logic [6:0] XSTART = 7'(X_START);
  localparam logic [6:0] XMIN   = 7'(X_MIN);
  localparam logic [6:0] XMAX   = 7'(X_MAX);
  localparam logic [6:0] YGND   = 7'(Y_GROUND);
  localparam logic [6:0] YTOP   = 7'(Y_GROUND - JUMP_HEIGHT);

  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  // Edges are caught every clk; edges seen on the tick cycle itself are used
  // directly so nothing is lost between latch clear and consumption.
  logic [NUM_STEPS-1:0] btn_now, btn_prev, edge_lat, edges;
  logic                 hit_lat, hit;

  assign btn_now = {btn_attack, btn_down, btn_up, btn_right, btn_left};
  assign edges   = edge_lat | (btn_now & ~btn_prev);
  assign hit     = hit_lat | hit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= '0;
      edge_lat <= '0;
      hit_lat  <= 1'b0;
    end else begin
      btn_prev <= btn_now;
      edge_lat <= tick ? '0 : edges;
      hit_lat  <= tick ? 1'b0 : hit;
    end
  end

  logic special_done;

  combo_detector #(.WINDOW(COMBO_WINDOW), .LEN(SPECIAL_LEN), .SEQ(SPECIAL_SEQ)) u_special (
    .clk(clk), .reset(reset), .tick(tick), .edges(edges), .done(special_done)
  );

`ifdef SUPER_COMBO_EN
  logic super_done;

  combo_detector #(.WINDOW(COMBO_WINDOW), .LEN(SUPER_LEN), .SEQ(SUPER_SEQ)) u_super (
    .clk(clk), .reset(reset), .tick(tick), .edges(edges), .done(super_done)
  );
`endif

  char_state_e act_q, act_d;
  jump_state_e js_q, js_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [6:0]    x_d, y_d;
  move_state_e   ms_d;
  logic          mirror_d;
  logic          go_left, go_right;

  assign go_left  = btn_left & ~btn_right;
  assign go_right = btn_right & ~btn_left;

  always_comb begin
    act_d    = act_q;
    dur_d    = dur_q;
    js_d     = js_q;
    x_d      = x;
    y_d      = y;
    ms_d     = MS_IDLE;
    mirror_d = mirror;

    if (hit) begin
      act_d = CS_INJURED;
      dur_d = DW'(INJ_TICKS);
    end
`ifdef SUPER_COMBO_EN
    else if (act_q == CS_NORMAL && super_done) begin
      act_d = CS_SUPER;
      dur_d = DW'(2 * SPECIAL_TICKS);
    end
`endif
    else if (act_q == CS_NORMAL && special_done) begin
      act_d = CS_SPECIAL;
      dur_d = DW'(SPECIAL_TICKS);
    end else if (act_q == CS_NORMAL && edges[STEP_ATTACK]) begin
      act_d = CS_PUNCH;
      dur_d = DW'(PUNCH_TICKS);
    end else if (act_q != CS_NORMAL) begin
      dur_d = dur_q - DW'(1);
      if (dur_q <= DW'(1)) act_d = CS_NORMAL;
    end

    // Facing decides forward/backward; knockback pushes against facing.
    if (act_q == CS_NORMAL) begin
      if (go_left && x > XMIN) begin
        x_d  = x - 7'd1;
        ms_d = mirror ? MS_FWD : MS_BACK;
      end else if (go_right && x < XMAX) begin
        x_d  = x + 7'd1;
        ms_d = mirror ? MS_BACK : MS_FWD;
      end
    end else if (act_q == CS_INJURED) begin
      if (mirror && x < XMAX)       x_d = x + 7'd1;
      else if (!mirror && x > XMIN) x_d = x - 7'd1;
    end
    if (act_d != CS_NORMAL) ms_d = MS_IDLE;

    if (act_q == CS_NORMAL && js_q == JS_GROUND) mirror_d = (opponent_x < x);

    case (js_q)
      JS_GROUND: begin
        if (edges[STEP_UP] && (act_q == CS_NORMAL || act_q == CS_PUNCH)) begin
          y_d  = y - 7'd1;
          js_d = (y_d == YTOP) ? JS_FALL : JS_RISE;
        end
      end
      JS_RISE: begin
        y_d = y - 7'd1;
        if (y_d == YTOP) js_d = JS_FALL;
      end
      JS_FALL: begin
        y_d = y + 7'd1;
        if (y_d == YGND) js_d = JS_GROUND;
      end
      default: js_d = JS_GROUND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q      <= CS_NORMAL;
      dur_q      <= '0;
      js_q       <= JS_GROUND;
      x          <= XSTART;
      y          <= YGND;
      move_state <= MS_IDLE;
      mirror     <= MIRROR_INIT;
    end else if (tick) begin
      act_q      <= act_d;
      dur_q      <= dur_d;
      js_q       <= js_d;
      x          <= x_d;
      y          <= y_d;
      move_state <= ms_d;
      mirror     <= mirror_d;
    end
  end

  assign character_state = act_q;
  assign in_air          = (js_q != JS_GROUND);

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// Bench for fighter_motion_ctrl at TICK_DIV=4: directed vector table, then
// random button/hit traffic scored against a tick-level reference model.
module tb_fighter_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_attack = 1'b0;
  logic       hit_in = 1'b0;
  logic [6:0] opponent_x = 7'd80;
  logic [6:0] x, y;
  logic       in_air, mirror;
  logic [1:0] move_state;
  logic [2:0] character_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fighter_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_attack(btn_attack), .hit_in(hit_in),
    .opponent_x(opponent_x),
    .x(x), .y(y), .in_air(in_air), .move_state(move_state),
    .character_state(character_state), .mirror(mirror)
  );

  localparam logic [4:0] N = 5'd0, L = 5'd1, R = 5'd2, U = 5'd4, D = 5'd8, A = 5'd16;

  typedef struct {
    logic [4:0] btn;
    logic       hit;
    logic [6:0] opp;
    int         n;
    logic       rst;
    int         ex, ey, eair, ems, ecs, emir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [4:0] b, input logic h, input int n, input logic r,
                             input int ex, input int ey, input int eair, input int ems,
                             input int ecs, input int emir);
    vec_t t;
    t.btn = b; t.hit = h; t.opp = 7'd80; t.n = n; t.rst = r;
    t.ex = ex; t.ey = ey; t.eair = eair; t.ems = ems; t.ecs = ecs; t.emir = emir;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int eair,
                         input int ems, input int ecs, input int emir);
    chk({tag, " x"}, x, ex);
    chk({tag, " y"}, y, ey);
    chk({tag, " in_air"}, in_air, eair);
    chk({tag, " move_state"}, move_state, ems);
    chk({tag, " character_state"}, character_state, ecs);
    chk({tag, " mirror"}, mirror, emir);
  endtask

  // One game tick: inputs applied just after the previous tick edge, the
  // optional hit pulse lasts one clk, outputs sampled 1 time unit after the tick.
  task automatic drive(input logic [4:0] b, input logic h, input logic [6:0] o);
    {btn_attack, btn_down, btn_up, btn_right, btn_left} = b;
    opponent_x = o;
    hit_in = h;
    @(posedge clk);
    #1 hit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    {btn_attack, btn_down, btn_up, btn_right, btn_left} = 5'd0;
    hit_in = 1'b0;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Reference model: jump as a phase counter, combo as step index plus the
  // tick number of the last accepted step, durations as remaining-tick counts.
  int mx, mjt, mmir, mcs, mrem, mprog, mlast, mnow, mms;
  logic [4:0] mprev;
  int combo_seq[4] = '{0, 3, 1, 4};

  function automatic void model_reset();
    mx = 24; mjt = 0; mmir = 0; mcs = 0; mrem = 0;
    mprog = 0; mlast = 0; mnow = 0; mms = 0; mprev = 5'd0;
  endfunction

  function automatic int model_y();
    return 32 - ((mjt <= 16) ? mjt : 32 - mjt);
  endfunction

  function automatic void model_tick(input logic [4:0] b, input logic h, input int o);
    logic [4:0] e;
    int nx, ms, done;
    mnow++;
    e = b & ~mprev;
    mprev = b;
    nx = mx; ms = 0;
    if (mcs == 0) begin
      if (b[0] && !b[1] && mx > 8) begin nx = mx - 1; ms = mmir ? 1 : 2; end
      else if (b[1] && !b[0] && mx < 88) begin nx = mx + 1; ms = mmir ? 2 : 1; end
    end else if (mcs == 4) begin
      nx = mmir ? ((mx < 88) ? mx + 1 : 88) : ((mx > 8) ? mx - 1 : 8);
    end
    if (mcs == 0 && mjt == 0) mmir = (o < mx) ? 1 : 0;
    mx = nx;
    if (mjt == 0) begin
      if (e[2] && (mcs == 0 || mcs == 1)) mjt = 1;
    end else begin
      mjt = (mjt + 1) % 32;
    end
    if (mprog > 0 && mnow - mlast > 8) mprog = 0;
    done = 0;
    if (e[combo_seq[mprog]]) begin
      mlast = mnow;
      mprog++;
      if (mprog == 4) begin mprog = 0; done = 1; end
    end else if (e[3:0] != 4'd0) begin
      mlast = mnow;
      mprog = e[0] ? 1 : 0;
    end
    if (h) begin mcs = 4; mrem = 6; end
    else if (mcs == 0 && done == 1) begin mcs = 2; mrem = 8; end
    else if (mcs == 0 && e[4]) begin mcs = 1; mrem = 4; end
    else if (mcs != 0) begin
      mrem--;
      if (mrem == 0) mcs = 0;
    end
    mms = (mcs == 0) ? ms : 0;
  endfunction

  initial begin
    logic [4:0] lv;
    logic       h;
    int         o;

    tbl.push_back(v(N, 0,  2, 1, 24, 32, 0, 0, 0, 0));
    tbl.push_back(v(R, 0, 10, 0, 34, 32, 0, 1, 0, 0));
    tbl.push_back(v(L, 0, 26, 0,  8, 32, 0, 2, 0, 0));
    tbl.push_back(v(L, 0,  2, 0,  8, 32, 0, 0, 0, 0));
    tbl.push_back(v(N, 0,  1, 0,  8, 32, 0, 0, 0, 0));
    tbl.push_back(v(U, 0,  1, 0,  8, 31, 1, 0, 0, 0));
    tbl.push_back(v(N, 0, 15, 0,  8, 16, 1, 0, 0, 0));
    tbl.push_back(v(N, 0,  1, 0,  8, 17, 1, 0, 0, 0));
    tbl.push_back(v(N, 0, 14, 0,  8, 31, 1, 0, 0, 0));
    tbl.push_back(v(N, 0,  1, 0,  8, 32, 0, 0, 0, 0));
    tbl.push_back(v(A, 0,  1, 0,  8, 32, 0, 0, 1, 0));
    tbl.push_back(v(N, 0,  3, 0,  8, 32, 0, 0, 1, 0));
    tbl.push_back(v(N, 0,  1, 0,  8, 32, 0, 0, 0, 0));
    tbl.push_back(v(R, 0, 20, 0, 28, 32, 0, 1, 0, 0));
    tbl.push_back(v(A, 0,  1, 0, 28, 32, 0, 0, 1, 0));
    tbl.push_back(v(N, 0,  1, 0, 28, 32, 0, 0, 1, 0));
    tbl.push_back(v(N, 1,  1, 0, 28, 32, 0, 0, 4, 0));
    tbl.push_back(v(N, 0,  5, 0, 23, 32, 0, 0, 4, 0));
    tbl.push_back(v(N, 0,  1, 0, 22, 32, 0, 0, 0, 0));
    tbl.push_back(v(L, 0,  1, 0, 21, 32, 0, 2, 0, 0));
    tbl.push_back(v(N, 0,  2, 0, 21, 32, 0, 0, 0, 0));
    tbl.push_back(v(D, 0,  1, 0, 21, 32, 0, 0, 0, 0));
    tbl.push_back(v(N, 0,  2, 0, 21, 32, 0, 0, 0, 0));
    tbl.push_back(v(R, 0,  1, 0, 22, 32, 0, 1, 0, 0));
    tbl.push_back(v(N, 0,  2, 0, 22, 32, 0, 0, 0, 0));
    tbl.push_back(v(A, 0,  1, 0, 22, 32, 0, 0, 2, 0));
    tbl.push_back(v(N, 0,  7, 0, 22, 32, 0, 0, 2, 0));
    tbl.push_back(v(N, 0,  1, 0, 22, 32, 0, 0, 0, 0));
    tbl.push_back(v(L, 0,  1, 0, 21, 32, 0, 2, 0, 0));
    tbl.push_back(v(N, 0,  2, 0, 21, 32, 0, 0, 0, 0));
    tbl.push_back(v(D, 0,  1, 0, 21, 32, 0, 0, 0, 0));
    tbl.push_back(v(N, 0,  2, 0, 21, 32, 0, 0, 0, 0));
    tbl.push_back(v(R, 0,  1, 0, 22, 32, 0, 1, 0, 0));
    tbl.push_back(v(N, 0,  8, 0, 22, 32, 0, 0, 0, 0));
    tbl.push_back(v(A, 0,  1, 0, 22, 32, 0, 0, 1, 0));
    tbl.push_back(v(N, 0,  4, 0, 22, 32, 0, 0, 0, 0));
    tbl.push_back(v(U, 0,  1, 0, 22, 31, 1, 0, 0, 0));
    tbl.push_back(v(N, 0, 10, 0, 22, 21, 1, 0, 0, 0));
    tbl.push_back(v(A, 0,  1, 0, 22, 20, 1, 0, 1, 0));
    tbl.push_back(v(N, 0,  1, 1, 24, 32, 0, 0, 0, 0));
    tbl.push_back(v(N, 0,  5, 0, 24, 32, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset(tbl[i].n);
      end else begin
        for (int k = 0; k < tbl[i].n; k++)
          drive(tbl[i].btn, (k == 0) ? tbl[i].hit : 1'b0, tbl[i].opp);
      end
      chk_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].eair,
              tbl[i].ems, tbl[i].ecs, tbl[i].emir);
    end

    do_reset(2);
    model_reset();
    lv = 5'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) lv = lv ^ (5'd1 << $urandom_range(0, 4));
      if (i % 60 == 59) lv = 5'd0;
      h = ($urandom_range(0, 24) == 0);
      o = $urandom_range(0, 100);
      drive(lv, h, 7'(o));
      model_tick(lv, h, o);
      chk_all($sformatf("rnd%0d", i), mx, model_y(), (mjt != 0) ? 1 : 0, mms, mcs, mmir);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
